uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 142 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time parity/stop/prescale config latched per frame.
// Optional UART_RX_MAJ3_EN: 2-of-3 majority sampling around the bit centre.
module uart_rx_cfg #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STP2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_W-1:0]     P_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);

  state_t                  state, next_state;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [3:0]              bit_cnt;
  logic                    sh_par_en, sh_par_typ, sh_stp2;
  logic [PRESCALE_W-1:0]   sh_prescale;
  logic [DATA_W-1:0]       data_sr;
  logic                    par_flag, stp_flag;
  logic                    first_cyc;

  logic [PRESCALE_W-1:0]   half, last, sample_pt;
  logic                    sample_now, bit_end, bit_val, frame_start;

  assign half    = sh_prescale >> 1;
  assign last    = sh_prescale - PRESCALE_W'(1);
  assign bit_end = (edge_cnt == last);

`ifdef UART_RX_MAJ3_EN
  logic samp_a, samp_b;
  // Decision is taken on the third sample, one edge after the centre.
  assign sample_pt = half + PRESCALE_W'(1);
  assign bit_val   = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1)) samp_a <= RX_IN;
      if (edge_cnt == half)                  samp_b <= RX_IN;
    end
  end
`else
  assign sample_pt = half;
  assign bit_val   = RX_IN;
`endif

  assign sample_now  = (edge_cnt == sample_pt);
  assign frame_start = ((state == IDLE) || (state == DONE)) && (next_state == START);
  assign fsm_state   = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!RX_IN && !first_cyc) next_state = START;
      START: begin
        if (sample_now && bit_val) next_state = IDLE;
        else if (bit_end)          next_state = DATA;
      end
      DATA:   if (bit_end && bit_cnt == LAST_DATA) next_state = sh_par_en ? PARITY : STOP;
      PARITY: if (bit_end) next_state = STOP;
      STOP:   if (bit_end && bit_cnt == {3'b000, sh_stp2}) next_state = DONE;
      DONE:   next_state = RX_IN ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      sh_par_en   <= 1'b0;
      sh_par_typ  <= 1'b0;
      sh_stp2     <= 1'b0;
      sh_prescale <= '0;
      data_sr     <= '0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      first_cyc   <= 1'b1;
      P_data      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      first_cyc  <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      // The cycle that saw the falling edge counts as edge 0 of the start bit.
      if (next_state != state)  edge_cnt <= (next_state == START) ? PRESCALE_W'(1) : '0;
      else if (state == IDLE)   edge_cnt <= '0;
      else if (bit_end)         edge_cnt <= '0;
      else                      edge_cnt <= edge_cnt + PRESCALE_W'(1);

      if (next_state != state) bit_cnt <= '0;
      else if (bit_end && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 4'd1;

      if (frame_start) begin
        sh_par_en   <= PAR_EN;
        sh_par_typ  <= PAR_TYP;
        sh_stp2     <= STP2;
        sh_prescale <= prescale;
        par_flag    <= 1'b0;
        stp_flag    <= 1'b0;
      end

      if (state == DATA && sample_now) data_sr <= {bit_val, data_sr[DATA_W-1:1]};
      if (state == PARITY && sample_now && (bit_val != (^data_sr ^ sh_par_typ))) par_flag <= 1'b1;
      if (state == STOP && sample_now && !bit_val) stp_flag <= 1'b1;

      // Pulses are registered so they are visible throughout the DONE cycle.
      if (state == STOP && next_state == DONE) begin
        par_err <= par_flag;
        stp_err <= stp_flag;
        if (!par_flag && !stp_flag) begin
          data_valid <= 1'b1;
          P_data     <= data_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: one task per scenario, pulse monitor on negedge.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en, par_typ, stp2;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;
  logic [2:0] fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;

  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  logic [7:0] got_q[$];

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;

  uart_rx_cfg #(.DATA_W(8), .PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .RX_IN(rx_in),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STP2(stp2), .prescale(prescale),
    .P_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        dv_cnt++;
        got_q.push_back(p_data);
      end
      if (par_err) pe_cnt++;
      if (stp_err) se_cnt++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Holds one bit for p clocks; clock index g (if in range) gets the inverted level.
  task automatic send_bit(input logic b, input int p, input int g);
    for (int k = 0; k < p; k++) begin
      @(negedge clk);
      rx_in = (k == g) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic pbit, input int nstop, input logic stop2_val,
                            input int gbit, input int gedge);
    send_bit(1'b0, p, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, (i == gbit) ? gedge : -1);
    if (pen) send_bit(pbit, p, -1);
    send_bit(1'b1, p, -1);
    if (nstop == 2) send_bit(stop2_val, p, -1);
  endtask

  task automatic check_counts(input string name, input int dv_exp, input int pe_exp,
                              input int se_exp, input int dv0, input int pe0, input int se0);
    tests_run++;
    if ((dv_cnt - dv0) !== dv_exp) begin
      tests_failed++;
      $display("FAIL %s data_valid pulses: got %0d expected %0d", name, dv_cnt - dv0, dv_exp);
    end
    tests_run++;
    if ((pe_cnt - pe0) !== pe_exp) begin
      tests_failed++;
      $display("FAIL %s par_err pulses: got %0d expected %0d", name, pe_cnt - pe0, pe_exp);
    end
    tests_run++;
    if ((se_cnt - se0) !== se_exp) begin
      tests_failed++;
      $display("FAIL %s stp_err pulses: got %0d expected %0d", name, se_cnt - se0, se_exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; rx_in = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stp2 = 1'b0; prescale = 6'd8;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({p_data, data_valid, par_err, stp_err} !== 11'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", {p_data, data_valid, par_err, stp_err});
    end
    tests_run++;
    if (fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL first_cycle_ignored: got %0d expected %0d", fsm_state, ST_IDLE);
    end
    rx_in = 1'b1;
    idle(20);
    tests_run++;
    if (fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %0d expected %0d", fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_even_parity;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b1; par_typ = 1'b0; stp2 = 1'b0; prescale = 6'd8;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1, 1'b1, -1, -1);
    idle(16);
    check_counts("even_parity", 1, 0, 0, dv0, pe0, se0);
    tests_run++;
    if (p_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL even_parity_data: got %h expected a5", p_data);
    end
  endtask

  task automatic test_odd_parity_err;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b1; par_typ = 1'b1; stp2 = 1'b0; prescale = 6'd8;
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1, 1'b1, -1, -1);
    idle(16);
    check_counts("odd_parity_err", 0, 1, 0, dv0, pe0, se0);
    tests_run++;
    if (p_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL odd_parity_hold: got %h expected a5", p_data);
    end
  endtask

  task automatic test_stop2;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b0; par_typ = 1'b0; stp2 = 1'b1; prescale = 6'd8;
    send_frame(8'h55, 8, 1'b0, 1'b0, 2, 1'b0, -1, -1);
    idle(16);
    check_counts("stop2_err", 0, 0, 1, dv0, pe0, se0);
    // Good two-stop frame with odd parity must still be accepted.
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b1; par_typ = 1'b1;
    send_frame(8'h3C, 8, 1'b1, 1'b1, 2, 1'b1, -1, -1);
    idle(16);
    check_counts("stop2_ok", 1, 0, 0, dv0, pe0, se0);
    tests_run++;
    if (p_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL stop2_ok_data: got %h expected 3c", p_data);
    end
  endtask

  task automatic test_start_glitch;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b0; stp2 = 1'b0; prescale = 6'd16;
    send_bit(1'b0, 3, -1);
    idle(40);
    check_counts("start_glitch", 0, 0, 0, dv0, pe0, se0);
    tests_run++;
    if (fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL start_glitch_state: got %0d expected %0d", fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_back_to_back;
    int dv0, pe0, se0;
    logic [7:0] d;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    got_q.delete();
    par_en = 1'b0; stp2 = 1'b0; prescale = 6'd8;
    send_bit(1'b0, 8, -1);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 8, -1);
      if (i == 3) prescale = 6'd16;
    end
    send_bit(1'b1, 8, -1);
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    idle(32);
    check_counts("back_to_back", 2, 0, 0, dv0, pe0, se0);
    tests_run++;
    d = (got_q.size() > 0) ? got_q.pop_front() : 8'hXX;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h expected 00", d);
    end
    tests_run++;
    d = (got_q.size() > 0) ? got_q.pop_front() : 8'hXX;
    if (d !== 8'hFF) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h expected ff", d);
    end
  endtask

  task automatic test_maj3_glitch;
    int dv0, pe0, se0;
    logic [7:0] exp_d;
`ifdef UART_RX_MAJ3_EN
    exp_d = 8'hA5;
`else
    exp_d = 8'hAD;
`endif
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b0; stp2 = 1'b0; prescale = 6'd8;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 3, 4);
    idle(16);
    check_counts("maj3_glitch", 1, 0, 0, dv0, pe0, se0);
    tests_run++;
    if (p_data !== exp_d) begin
      tests_failed++;
      $display("FAIL maj3_glitch_data: got %h expected %h", p_data, exp_d);
    end
  endtask

  task automatic test_reset_mid_frame;
    int dv0, pe0, se0;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    par_en = 1'b0; stp2 = 1'b0; prescale = 6'd8;
    send_bit(1'b0, 8, -1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 8, -1);
    @(negedge clk);
    rst = 1'b0; rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(80);
    check_counts("reset_mid_frame", 0, 0, 0, dv0, pe0, se0);
    tests_run++;
    if (p_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_frame_data: got %h expected 00", p_data);
    end
    tests_run++;
    if (fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid_frame_state: got %0d expected %0d", fsm_state, ST_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity_err();
    test_stop2();
    test_start_glitch();
    test_back_to_back();
    test_maj3_glitch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
